sram_dff_param: RTL and testbench
=================================

Name: sram_dff_param

Overview:
- Parametrised flip-flop register-file memory with one write port and one read port. Supersedes the fixed 8 x 32 D-FF SRAM.
- Generalised in depth and width, with per-byte write enables.
- Read path is registered, with a valid strobe and selectable read-during-write mode.
- A sequencer can fill the whole array with a constant, one word per cycle.
- Used as the small scratch/register store in datapath blocks.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- DEPTH, 8, number of words; 2..256, need not be a power of two.
- ADDR_W, $clog2(DEPTH), address width.
- RDW_NEW, 1, read-during-write to the same address: 1 returns the new merged data, 0 returns the old data.
- FILL, 0, DATA_W-bit value written by the clear sequencer.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- we  in  1  write enable
- wadd  in  ADDR_W  write address
- wd  in  DATA_W  write data
- be  in  DATA_W/8  byte enables; bit i covers wd[8i+7:8i]
- re  in  1  read enable
- radd  in  ADDR_W  read address
- rd  out  DATA_W  registered read data
- rvalid  out  1  one-cycle strobe: rd updated this cycle
- clr  in  1  start fill sequence (level sampled in IDLE)
- busy  out  1  fill sequence in progress
- done  out  1  one-cycle strobe after the last fill word is written

Behaviour:
- Reset (reset=1 at posedge):
  - all DEPTH words = 0; rd = 0; rvalid = 0; busy = 0; done = 0.
  - FSM goes to IDLE; fill counter = 0.
  - Reset overrides every other input, including mid-fill.
- Write (IDLE, we=1, wadd<DEPTH):
  - at posedge, mem[wadd] byte i takes wd byte i where be[i]=1; bytes with be[i]=0 are unchanged.
  - be all-zero means no change.
- Out-of-range write (wadd>=DEPTH): dropped; no word changes.
- Read (IDLE, re=1):
  - at posedge, rd <= mem[radd] and rvalid <= 1. Latency is 1 cycle from re to rd/rvalid.
  - Out-of-range radd: rd <= 0, rvalid <= 1.
- re=0: rvalid <= 0 and rd holds its last value.
- Read-during-write, same address, same cycle:
  - RDW_NEW=1: rd gets the byte-merged result (enabled bytes from wd, others from old word).
  - RDW_NEW=0: rd gets the pre-write word.
  - Different addresses: independent.
- FSM states:
  - IDLE: if clr=1, go to FILL with counter = 0; busy rises the next cycle. we/re in the same cycle as clr are still serviced.
  - FILL: each cycle writes mem[counter] = FILL (all bytes), then counter++. The cycle with counter = DEPTH-1 writes the last word; the next state is IDLE, and done = 1 for exactly one cycle, coincident with busy falling to 0.
  - Fill therefore takes exactly DEPTH cycles with busy=1.
- While busy=1:
  - we and re are ignored: no writes, rvalid = 0, rd holds.
  - clr is ignored; it does not restart the sequence.
- The counter is sized to reach DEPTH-1 without wrap. It is never compared against 2^ADDR_W, so non-power-of-two DEPTH fills exactly DEPTH words.
- No combinational path from inputs to rd, rvalid, busy or done; all outputs are registered.

Test Plan:
- Reset, then read all addresses with DATA_W=32, DEPTH=8 -> each read gives rd=0x00000000 with rvalid=1 one cycle after re.
- Write 0xDEADBEEF to addr 3 with be=4'b1111, then write 0x11223344 to addr 3 with be=4'b0101, then read addr 3 -> rd=0xDE22BE44.
- Same-cycle write of 0xA5A5A5A5 to addr 5 (old value 0) with read of addr 5 -> rd=0xA5A5A5A5 when RDW_NEW=1; rd=0x00000000 when RDW_NEW=0. A following read returns 0xA5A5A5A5 in both builds.
- FILL=0x0F0F0F0F, DEPTH=8, pulse clr -> busy high for exactly 8 cycles; done pulses once as busy falls; we=1 to addr 0 mid-fill has no effect; all 8 words then read 0x0F0F0F0F.
- DEPTH=6, write 0x12345678 to addr 7 and read addr 7 -> no word changes; rd=0, rvalid=1. Fill sequence completes in 6 cycles.
- Assert reset during cycle 3 of a fill after writing 0xFFFFFFFF to addr 7 -> busy=0 and done=0 the next cycle, done never pulses, and all words read 0.

Source files
------------

// File: rtl/sram_dff_param.sv
// Parametrised flip-flop register file: one write port with byte enables, one registered
// read port with valid strobe, and a sequencer that fills every word with a constant.
module sram_dff_param #(
    parameter int                DATA_W  = 32,
    parameter int                DEPTH   = 8,
    parameter int                ADDR_W  = $clog2(DEPTH),
    parameter bit                RDW_NEW = 1'b1,
    parameter logic [DATA_W-1:0] FILL    = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     wadd,
    input  logic [DATA_W-1:0]     wd,
    input  logic [DATA_W/8-1:0]   be,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     radd,
    output logic [DATA_W-1:0]     rd,
    output logic                  rvalid,
    input  logic                  clr,
    output logic                  busy,
    output logic                  done
);

    localparam int BYTES = DATA_W / 8;

    typedef enum logic {
        S_IDLE,
        S_FILL
    } state_t;

    state_t              state, next_state;
    logic [ADDR_W-1:0]   cnt, cnt_next;
    logic                busy_next, done_next;
    logic                busy_p1, done_p1;
    logic [DATA_W-1:0]   rd_p1;
    logic                vld_p1;
    logic [DATA_W-1:0]   mem [DEPTH];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {{(32-ADDR_W){1'b0}}, a} < 32'(DEPTH);
    endfunction

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] new_w,
                                                input logic [BYTES-1:0]  en);
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < BYTES; i++) begin
            if (en[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        case (state)
            S_IDLE: begin
                if (clr) begin
                    next_state = S_FILL;
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                end
            end
            S_FILL: begin
                if (cnt == ADDR_W'(DEPTH - 1)) begin
                    next_state = S_IDLE;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    cnt_next  = cnt + 1'b1;
                    busy_next = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            busy_p1 <= 1'b0;
            done_p1 <= 1'b0;
        end else begin
            state   <= next_state;
            cnt     <= cnt_next;
            busy_p1 <= busy_next;
            done_p1 <= done_next;
        end
    end

    // Storage: the fill sequencer owns the array while it runs
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == S_FILL) begin
            mem[cnt] <= FILL;
        end else if (we && in_range(wadd)) begin
            mem[wadd] <= merge(mem[wadd], wd, be);
        end
    end

    // Read stage p1: one-cycle latency, same-address bypass selectable
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_p1  <= '0;
            vld_p1 <= 1'b0;
        end else if (state == S_FILL || !re) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= 1'b1;
            if (!in_range(radd))
                rd_p1 <= '0;
            else if (RDW_NEW && we && wadd == radd)
                rd_p1 <= merge(mem[radd], wd, be);
            else
                rd_p1 <= mem[radd];
        end
    end

    assign rd     = rd_p1;
    assign rvalid = vld_p1;
    assign busy   = busy_p1;
    assign done   = done_p1;

endmodule

// File: tb/tb_sram_dff_param.sv
// Directed bench for sram_dff_param: three builds (RDW new, RDW old, DEPTH=6) share stimulus.
module tb_sram_dff_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [2:0]  wadd = '0;
    logic [31:0] wd = '0;
    logic [3:0]  be = '0;
    logic        re = 1'b0;
    logic [2:0]  radd = '0;
    logic        clr = 1'b0;

    logic [31:0] rd0, rd1, rd2;
    logic        rv0, rv1, rv2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sram_dff_param #(.DATA_W(32), .DEPTH(8), .RDW_NEW(1'b1), .FILL(32'h0F0F0F0F)) u_new (
        .clk(clk), .reset(reset), .we(we), .wadd(wadd), .wd(wd), .be(be), .re(re), .radd(radd),
        .rd(rd0), .rvalid(rv0), .clr(clr), .busy(busy0), .done(done0));

    sram_dff_param #(.DATA_W(32), .DEPTH(8), .RDW_NEW(1'b0), .FILL(32'h0F0F0F0F)) u_old (
        .clk(clk), .reset(reset), .we(we), .wadd(wadd), .wd(wd), .be(be), .re(re), .radd(radd),
        .rd(rd1), .rvalid(rv1), .clr(clr), .busy(busy1), .done(done1));

    sram_dff_param #(.DATA_W(32), .DEPTH(6), .RDW_NEW(1'b1), .FILL(32'h0F0F0F0F)) u_d6 (
        .clk(clk), .reset(reset), .we(we), .wadd(wadd), .wd(wd), .be(be), .re(re), .radd(radd),
        .rd(rd2), .rvalid(rv2), .clr(clr), .busy(busy2), .done(done2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; re = 1'b0; clr = 1'b0; be = 4'h0; wd = '0; wadd = '0; radd = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
        total++;
        if (rd0 !== 32'h0 || rv0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: rd=%h rvalid=%b busy=%b done=%b required 0/0/0/0", rd0, rv0, busy0, done0);
        end
        for (int i = 0; i < 8; i++) begin
            re = 1'b1; radd = 3'(i);
            step();
            total++;
            if (rd0 !== 32'h0 || rv0 !== 1'b1) begin
                bad++;
                $display("FAIL reset_read[%0d]: rd=%h rvalid=%b required 00000000/1", i, rd0, rv0);
            end
        end
        re = 1'b0;
        step();
        total++;
        if (rv0 !== 1'b0) begin
            bad++;
            $display("FAIL rvalid_drop: rvalid=%b required 0", rv0);
        end
    endtask

    task automatic test_byte_write();
        we = 1'b1; wadd = 3'd3; wd = 32'hDEADBEEF; be = 4'b1111;
        step();
        wd = 32'h11223344; be = 4'b0101;
        step();
        wd = 32'h00000000; be = 4'b0000;
        step();
        we = 1'b0; re = 1'b1; radd = 3'd3;
        step();
        total++;
        if (rd0 !== 32'hDE22BE44 || rv0 !== 1'b1) begin
            bad++;
            $display("FAIL byte_merge: rd=%h rvalid=%b required DE22BE44/1", rd0, rv0);
        end
        re = 1'b0; radd = 3'd0;
        step();
        total++;
        if (rd0 !== 32'hDE22BE44 || rv0 !== 1'b0) begin
            bad++;
            $display("FAIL rd_hold: rd=%h rvalid=%b required DE22BE44/0", rd0, rv0);
        end
    endtask

    task automatic test_rdw();
        we = 1'b1; wadd = 3'd5; wd = 32'hA5A5A5A5; be = 4'b1111; re = 1'b1; radd = 3'd5;
        step();
        total++;
        if (rd0 !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL rdw_new: rd=%h required A5A5A5A5", rd0);
        end
        total++;
        if (rd1 !== 32'h00000000) begin
            bad++;
            $display("FAIL rdw_old: rd=%h required 00000000", rd1);
        end
        we = 1'b0;
        step();
        total++;
        if (rd0 !== 32'hA5A5A5A5 || rd1 !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL rdw_followup: rd_new=%h rd_old=%h required A5A5A5A5", rd0, rd1);
        end
        we = 1'b1; wadd = 3'd6; wd = 32'hCAFEF00D; be = 4'b1111; radd = 3'd3;
        step();
        total++;
        if (rd0 !== 32'hDE22BE44 || rd1 !== 32'hDE22BE44) begin
            bad++;
            $display("FAIL rdw_diff_addr: rd_new=%h rd_old=%h required DE22BE44", rd0, rd1);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_out_of_range();
        logic [31:0] exp6 [6];
        exp6 = '{32'h0, 32'h0, 32'h0, 32'hDE22BE44, 32'h0, 32'hA5A5A5A5};
        we = 1'b1; wadd = 3'd7; wd = 32'h12345678; be = 4'b1111; re = 1'b1; radd = 3'd7;
        step();
        total++;
        if (rd2 !== 32'h0 || rv2 !== 1'b1) begin
            bad++;
            $display("FAIL oob_read: rd=%h rvalid=%b required 00000000/1", rd2, rv2);
        end
        we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            radd = 3'(i);
            step();
            total++;
            if (rd2 !== exp6[i]) begin
                bad++;
                $display("FAIL oob_nochange[%0d]: rd=%h required %h", i, rd2, exp6[i]);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_fill();
        int  nb0 = 0, nb2 = 0, nd0 = 0, nd2 = 0;
        logic pb0, pb2;
        logic bad_align = 1'b0, bad_rv = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        pb0 = busy0; pb2 = busy2;
        if (busy0) nb0++;
        if (busy2) nb2++;
        for (int k = 0; k < 14; k++) begin
            we  = (k < 3);
            wadd = 3'd0; wd = 32'hFFFFFFFF; be = 4'b1111;
            re  = (k < 3);
            clr = (k == 1);
            step();
            if (k < 3 && rv0 !== 1'b0) bad_rv = 1'b1;
            if (busy0) nb0++;
            if (busy2) nb2++;
            if (done0) begin
                nd0++;
                if (busy0 !== 1'b0 || pb0 !== 1'b1) bad_align = 1'b1;
            end
            if (done2) begin
                nd2++;
                if (busy2 !== 1'b0 || pb2 !== 1'b1) bad_align = 1'b1;
            end
            pb0 = busy0; pb2 = busy2;
        end
        idle_inputs();
        total++;
        if (nb0 != 8) begin
            bad++;
            $display("FAIL fill_busy8: busy cycles=%0d required 8", nb0);
        end
        total++;
        if (nb2 != 6) begin
            bad++;
            $display("FAIL fill_busy6: busy cycles=%0d required 6", nb2);
        end
        total++;
        if (nd0 != 1 || nd2 != 1) begin
            bad++;
            $display("FAIL fill_done_count: done8=%0d done6=%0d required 1/1", nd0, nd2);
        end
        total++;
        if (bad_align !== 1'b0) begin
            bad++;
            $display("FAIL fill_done_align: misaligned=%b required 0", bad_align);
        end
        total++;
        if (bad_rv !== 1'b0) begin
            bad++;
            $display("FAIL fill_rvalid: rvalid seen=%b required 0", bad_rv);
        end
        for (int i = 0; i < 8; i++) begin
            re = 1'b1; radd = 3'(i);
            step();
            total++;
            if (rd0 !== 32'h0F0F0F0F || rd1 !== 32'h0F0F0F0F) begin
                bad++;
                $display("FAIL fill_word[%0d]: rd_new=%h rd_old=%h required 0F0F0F0F", i, rd0, rd1);
            end
            if (i < 6) begin
                total++;
                if (rd2 !== 32'h0F0F0F0F) begin
                    bad++;
                    $display("FAIL fill6_word[%0d]: rd=%h required 0F0F0F0F", i, rd2);
                end
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid_fill();
        int nd = 0;
        we = 1'b1; wadd = 3'd7; wd = 32'hFFFFFFFF; be = 4'b1111;
        step();
        we = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0) begin
            bad++;
            $display("FAIL abort_state: busy=%b/%b done=%b/%b required 0", busy0, busy2, done0, done2);
        end
        for (int k = 0; k < 10; k++) begin
            step();
            if (done0 || done1 || done2 || busy0) nd++;
        end
        total++;
        if (nd != 0) begin
            bad++;
            $display("FAIL abort_no_done: activity cycles=%0d required 0", nd);
        end
        for (int i = 0; i < 8; i++) begin
            re = 1'b1; radd = 3'(i);
            step();
            total++;
            if (rd0 !== 32'h0 || rd1 !== 32'h0) begin
                bad++;
                $display("FAIL abort_word[%0d]: rd_new=%h rd_old=%h required 00000000", i, rd0, rd1);
            end
        end
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_byte_write();
        test_rdw();
        test_out_of_range();
        test_fill();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
